regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file with per-entry pending scoreboard and a background clear sequencer. It is the operand store of the datapath: the decode stage reads source operands, reserves destinations, and the writeback stage writes results. All entries clear on synchronous reset, including the highest-index entry. A `clr` command starts a one-entry-per-cycle sweep without a full reset.

## Interface
- `DATA_W`, 8: entry width in bits
- `ADDR_W`, 4: address width; `DEPTH = 2**ADDR_W` entries
- `NUM_RD`, 2: number of read ports, 1..4
- `ZERO_R0`, 0: when 1, entry 0 reads as 0 always, and writes or reserves to it are discarded
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `src`  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- `rdata`  out  NUM_RD*DATA_W  read data; port k uses [k*DATA_W +: DATA_W]
- `rpend`  out  NUM_RD  pending bit of the entry addressed by port k
- `we`  in  1  write enable
- `dst`  in  ADDR_W  write address
- `data`  in  DATA_W  write data
- `rsv`  in  1  reserve request: sets the pending bit of `rsv_dst`
- `rsv_dst`  in  ADDR_W  entry to reserve
- `clr`  in  1  start clear sweep (single-cycle pulse)
- `busy`  out  1  sweep in progress
- `wr_err`  out  1  one-cycle pulse: a write or reserve was dropped during the sweep

## Operation
- Reads are combinational: `rdata[k] = mem[src[k]]`. `rpend[k] = pend[src[k]]`.
- Write: when `we=1` and the sequencer is in IDLE, `mem[dst] <= data` and `pend[dst] <= 0`.
- Reserve: when `rsv=1` and the sequencer is in IDLE, `pend[rsv_dst] <= 1`.
- If a write and a reserve target the same entry in the same cycle, the data is written and the pending bit ends at 1. Reserve wins.
- With `ZERO_R0=1`, `rdata` and `rpend` for address 0 are 0, and entry 0 is never modified.
- Sequencer states:
  - IDLE to SWEEP on `clr=1`. In that cycle all `pend` bits clear, the pointer is set to 0, and any `we` or `rsv` in the same cycle is dropped with `wr_err`.
  - SWEEP: each cycle sets `mem[ptr] <= 0` and increments `ptr`. After `ptr = DEPTH-1` is cleared, the sequencer returns to IDLE.
  - `clr` received in SWEEP is ignored. The sweep does not restart.
- During SWEEP, `we` and `rsv` are dropped. `wr_err` is 1 in the cycle after each dropped request.
- Reads during SWEEP return current contents: entries below `ptr` read 0, the rest read old data.
- Reset in any state: all `mem` = 0, all `pend` = 0, state IDLE, `ptr` = 0, `busy` = 0, `wr_err` = 0. Reset overrides `we`, `rsv` and `clr` in the same cycle.
- Reset values of outputs: `rdata` all 0, `rpend` all 0, `busy` 0, `wr_err` 0.

## Timing
- Write-to-read latency: 1 cycle without bypass (the data is visible the cycle after `we`), 0 cycles with bypass.
- Reserve-to-`rpend` latency: 1 cycle.
- `busy` rises the cycle after `clr` and stays high for exactly DEPTH cycles.
- After `busy` falls, the first write is accepted in that same cycle.
- `wr_err` is registered and is 1 for one cycle per dropped request.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - If `we=1`, the sequencer is IDLE and `src[k]==dst`, then `rdata[k]=data` combinationally.
  - In that case `rpend[k]` reads 0 unless `rsv` targets the same entry in the same cycle.
  - Bypass is suppressed for address 0 when `ZERO_R0=1`.
- `REGFILE_BYPASS_EN` undefined: there is no forwarding. Same-cycle reads of `dst` return the old value.

## Structure
- Shared package `regfile_pkg`:
  - sequencer state enum `{ST_IDLE, ST_SWEEP}`
  - default parameter constants for `DATA_W`, `ADDR_W` and `NUM_RD`
- One sub-module, `regfile_clr_seq`:
  - contains the state register, the pointer and the `busy`/`wr_err` generation
  - outputs `sweep_we` and `sweep_addr`, plus a `host_ok` qualifier that gates host writes and reserves
- The storage array, the `pend` vector and the read muxes (a generate loop over `NUM_RD`) live in the top level.

## Test plan
- Reset, then read all 16 addresses on both ports -> every `rdata`=0x00 and every `rpend`=0, including address 15.
- Write 0xA5 to entry 3, then read src0=3 and src1=3 the next cycle -> both 0xA5. With bypass, the same-cycle read also returns 0xA5.
- `rsv` on entry 7 -> `rpend`=1 next cycle. Write 0x11 to entry 7 -> `rpend`=0 and `rdata`=0x11. Simultaneous write and reserve on entry 7 -> `rdata`=data and `rpend`=1.
- Fill entries with 0xFF, pulse `clr`, write to entry 2 at sweep cycle 5 -> `busy` high for 16 cycles, `wr_err` pulses once, all entries read 0 after the sweep, and entry 2 is not 0xFF.
- Assert `rst` at sweep cycle 8 -> next cycle `busy`=0, all entries 0, all pending bits 0, and a write is accepted immediately.
- `ZERO_R0=1`: write 0x5A to entry 0 and `rsv` entry 0 -> reads of 0 return 0x00 with `rpend`=0. `NUM_RD=3` variant: three ports read distinct entries correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizing for the regfile_mp operand store.
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NUM_RD = 2;

    // Background clear sequencer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } seq_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: background clear sequencer for regfile_mp.
// Sweeps one entry per cycle after a clr pulse, blocks host writes/reserves
// while sweeping and flags each dropped request with a registered wr_err pulse.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic              rsv,
    output logic              host_ok,
    output logic              pend_clr,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              busy,
    output logic              wr_err
);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;
    logic              wr_err_q;

    // Host traffic is only honoured in IDLE and not in the cycle that starts a sweep.
    assign host_ok    = (state_q == ST_IDLE) && !clr;
    assign pend_clr   = (state_q == ST_IDLE) && clr;
    assign sweep_we   = (state_q == ST_SWEEP);
    assign sweep_addr = ptr_q;
    assign busy       = busy_q;
    assign wr_err     = wr_err_q;

    // Sequencer state, sweep pointer and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates from pre-edge values.
            wr_err_q <= (we || rsv) && !host_ok;
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        state_q <= ST_SWEEP;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with per-entry pending scoreboard
// and background clear sweep.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching read ports; without it, same-cycle reads of dst return old data.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int ZERO_R0 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] src,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rpend,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        dst,
    input  logic [DATA_W-1:0]        data,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_dst,
    input  logic                     clr,
    output logic                     busy,
    output logic                     wr_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    logic              host_ok;
    logic              pend_clr;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              wr_ok;
    logic              rsv_ok;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .we         (we),
        .rsv        (rsv),
        .host_ok    (host_ok),
        .pend_clr   (pend_clr),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .busy       (busy),
        .wr_err     (wr_err)
    );

    // Entry 0 is hard-wired to zero when ZERO_R0 is set, so its traffic is discarded.
    assign wr_ok  = we  && host_ok && !((ZERO_R0 != 0) && (dst == '0));
    assign rsv_ok = rsv && host_ok && !((ZERO_R0 != 0) && (rsv_dst == '0));

    // Next pending vector: clr wipes all, a write clears, a reserve sets (reserve wins).
    always_comb begin
        // NOTE: default assignment first so every path drives pend_d and no latch is inferred.
        pend_d = pend_q;
        if (pend_clr) begin
            pend_d = '0;
        end else begin
            if (wr_ok) begin
                pend_d[dst] = 1'b0;
            end
            if (rsv_ok) begin
                pend_d[rsv_dst] = 1'b1;
            end
        end
    end

    // Pending scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Storage array: reset clears every entry, the sweep owns the write port while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset on purpose; reset must leave every entry reading zero.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (sweep_we) begin
            mem_q[sweep_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[dst] <= data;
        end
    end

    // Combinational read ports.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero_hit;

        assign addr     = src[k*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_R0 != 0) && (addr == '0);

`ifdef REGFILE_BYPASS_EN
        logic byp_hit;

        assign byp_hit = we && host_ok && (addr == dst) && !zero_hit;
        assign rdata[k*DATA_W +: DATA_W] = zero_hit ? '0 :
                                           byp_hit  ? data : mem_q[addr];
        assign rpend[k] = zero_hit ? 1'b0 :
                          byp_hit  ? (rsv && (rsv_dst == addr)) : pend_q[addr];
`else
        assign rdata[k*DATA_W +: DATA_W] = zero_hit ? '0 : mem_q[addr];
        assign rpend[k] = zero_hit ? 1'b0 : pend_q[addr];
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (default instance plus a
// ZERO_R0=1, NUM_RD=3 instance).
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NR    = 2;
    localparam int NZ    = 3;
    localparam int DEPTH = 16;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NR*AW-1:0] src;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0] rpend;
    logic          we, rsv, clr, busy, wr_err;
    logic [AW-1:0] dst, rsv_dst;
    logic [DW-1:0] data;

    logic [NZ*AW-1:0] z_src;
    logic [NZ*DW-1:0] z_rdata;
    logic [NZ-1:0] z_rpend;
    logic          z_we, z_rsv, z_clr, z_busy, z_wr_err;
    logic [AW-1:0] z_dst, z_rsv_dst;
    logic [DW-1:0] z_data;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst), .src(src), .rdata(rdata), .rpend(rpend),
        .we(we), .dst(dst), .data(data), .rsv(rsv), .rsv_dst(rsv_dst),
        .clr(clr), .busy(busy), .wr_err(wr_err)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NZ), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .src(z_src), .rdata(z_rdata), .rpend(z_rpend),
        .we(z_we), .dst(z_dst), .data(z_data), .rsv(z_rsv), .rsv_dst(z_rsv_dst),
        .clr(z_clr), .busy(z_busy), .wr_err(z_wr_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Read scoreboard: expectations pushed when src is driven, popped when sampled.
    typedef struct {
        bit          z;
        int          port;
        logic [7:0]  d;
        logic        p;
        string       name;
    } rd_exp_t;

    rd_exp_t rq[$];

    task automatic rd(input bit z, input int port, input logic [AW-1:0] a,
                      input logic [7:0] d, input logic p, input string name);
        rd_exp_t e;
        if (z) z_src[port*AW +: AW] = a;
        else   src[port*AW +: AW]   = a;
        e.z = z; e.port = port; e.d = d; e.p = p; e.name = name;
        rq.push_back(e);
    endtask

    task automatic drain_rd();
        rd_exp_t    e;
        logic [7:0] ad;
        logic       ap;
        while (rq.size() > 0) begin
            e = rq.pop_front();
            if (e.z) begin
                ad = z_rdata[e.port*DW +: DW];
                ap = z_rpend[e.port];
            end else begin
                ad = rdata[e.port*DW +: DW];
                ap = rpend[e.port];
            end
            check({e.name, "_data"}, 32'(ad), 32'(e.d));
            check({e.name, "_pend"}, 32'(ap), 32'(e.p));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
        logic          rsv;
        logic [AW-1:0] rsv_dst;
        logic [AW-1:0] s0, s1;
        logic [DW-1:0] e0, e1;
        logic          p0, p1;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  busy_cnt;
        bit  done;

        //            we  dst    data   rsv rdst   s0     s1     e0     e1     p0    p1
        vecs[0]  = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0, 4'd0,  4'd15, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7, 4'd3,  4'd3,  8'hA5, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd7,  4'd3,  8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'd7,  8'h11, 1'b0, 4'd0, 4'd3,  4'd0,  8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd7,  4'd7,  8'h11, 8'h11, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'd7,  8'h22, 1'b1, 4'd7, 4'd3,  4'd1,  8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd7,  4'd3,  8'h22, 8'hA5, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'd9,  8'h3C, 1'b1, 4'd2, 4'd7,  4'd0,  8'h22, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd2,  4'd9,  8'h00, 8'h3C, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'd2,  8'h77, 1'b0, 4'd0, 4'd7,  4'd9,  8'h22, 8'h3C, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd2,  4'd9,  8'h77, 8'h3C, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'd15, 8'hEE, 1'b0, 4'd0, 4'd14, 4'd1,  8'h00, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd15, 4'd15, 8'hEE, 8'hEE, 1'b0, 1'b0};

        rst = 1'b1; src = '0; we = 1'b0; dst = '0; data = '0; rsv = 1'b0; rsv_dst = '0; clr = 1'b0;
        z_src = '0; z_we = 1'b0; z_dst = '0; z_data = '0; z_rsv = 1'b0; z_rsv_dst = '0; z_clr = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state: every entry and pending bit reads zero, including entry 15.
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            rd(0, 0, AW'(a), 8'h00, 1'b0, $sformatf("rst_p0_a%0d", a));
            rd(0, 1, AW'(DEPTH - 1 - a), 8'h00, 1'b0, $sformatf("rst_p1_a%0d", DEPTH - 1 - a));
            #2;
            drain_rd();
            step();
        end

        // Table-driven write / reserve / read vectors.
        for (int i = 0; i < NV; i++) begin
            we = vecs[i].we; dst = vecs[i].dst; data = vecs[i].data;
            rsv = vecs[i].rsv; rsv_dst = vecs[i].rsv_dst;
            rd(0, 0, vecs[i].s0, vecs[i].e0, vecs[i].p0, $sformatf("vec%0d_p0", i));
            rd(0, 1, vecs[i].s1, vecs[i].e1, vecs[i].p1, $sformatf("vec%0d_p1", i));
            #2;
            drain_rd();
            step();
        end
        we = 1'b0; rsv = 1'b0;

        // Same-cycle read of the write target: forwarded only with bypass.
        we = 1'b1; dst = 4'd3; data = 8'h5B;
        rd(0, 0, 4'd3, BYP ? 8'h5B : 8'hA5, 1'b0, "same_cyc_p0");
        rd(0, 1, 4'd3, BYP ? 8'h5B : 8'hA5, 1'b0, "same_cyc_p1");
        #2; drain_rd(); step();
        data = 8'h6C; rsv = 1'b1; rsv_dst = 4'd3;
        rd(0, 0, 4'd3, BYP ? 8'h6C : 8'h5B, BYP, "same_cyc_rsv");
        #2; drain_rd(); step();
        we = 1'b0; rsv = 1'b0;
        rd(0, 0, 4'd3, 8'h6C, 1'b1, "wr_rsv_after");
        #2; drain_rd(); step();

        // Clear sweep: fill with 0xFF, pulse clr, write at sweep cycle 5, clr again at cycle 3.
        for (int a = 0; a < DEPTH; a++) begin
            we = 1'b1; dst = AW'(a); data = 8'hFF;
            step();
        end
        we = 1'b0; rsv = 1'b1; rsv_dst = 4'd5;
        step();
        rsv = 1'b0; clr = 1'b1;
        #2;
        check("clr_cyc_busy", 32'(busy), 32'd0);
        step();
        clr = 1'b0;
        busy_cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            check($sformatf("sweep%0d_wr_err", i), 32'(wr_err), 32'(i == 6));
            we = (i == 5); dst = 4'd2; data = 8'h99;
            clr = (i == 3);
            if (i == 0) begin
                rd(0, 0, 4'd5, 8'hFF, 1'b0, "sweep0_e5");
                rd(0, 1, 4'd0, 8'hFF, 1'b0, "sweep0_e0");
            end
            if (i == 5) begin
                rd(0, 0, 4'd4, 8'h00, 1'b0, "sweep5_e4");
                rd(0, 1, 4'd5, 8'hFF, 1'b0, "sweep5_e5");
            end
            #2;
            drain_rd();
            busy_cnt++;
            step();
        end
        we = 1'b0; clr = 1'b0;
        check("sweep_ended", 32'(done), 32'd1);
        check("sweep_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        check("sweep_end_wr_err", 32'(wr_err), 32'd0);
        // First write accepted in the cycle busy falls.
        we = 1'b1; dst = 4'd6; data = 8'h42;
        step();
        we = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd(0, 0, AW'(a), (a == 6) ? 8'h42 : 8'h00, 1'b0, $sformatf("post_sweep_p0_a%0d", a));
            #2; drain_rd(); step();
        end

        // Reset at sweep cycle 8 overrides everything, including same-cycle requests.
        for (int a = 11; a < DEPTH; a++) begin
            we = 1'b1; dst = AW'(a); data = 8'hB0 + 8'(a);
            step();
        end
        we = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (8) step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1; we = 1'b1; dst = 4'd9; data = 8'h77; rsv = 1'b1; rsv_dst = 4'd10; clr = 1'b1;
        step();
        rst = 1'b0; rsv = 1'b0; clr = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wr_err", 32'(wr_err), 32'd0);
        we = 1'b1; dst = 4'd10; data = 8'h5C;
        step();
        we = 1'b0;
        check("post_rst_wr_err", 32'(wr_err), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            rd(0, 0, AW'(a), (a == 10) ? 8'h5C : 8'h00, 1'b0, $sformatf("post_rst_a%0d", a));
            #2; drain_rd(); step();
        end

        // ZERO_R0=1, NUM_RD=3 instance.
        z_we = 1'b1; z_dst = 4'd0; z_data = 8'h5A; z_rsv = 1'b1; z_rsv_dst = 4'd0;
        for (int k = 0; k < NZ; k++) rd(1, k, 4'd0, 8'h00, 1'b0, $sformatf("z_same_p%0d", k));
        #2; drain_rd(); step();
        z_dst = 4'd1; z_data = 8'h31; z_rsv = 1'b0;
        step();
        z_dst = 4'd2; z_data = 8'h32; z_rsv = 1'b1; z_rsv_dst = 4'd3;
        step();
        z_we = 1'b0; z_rsv = 1'b0;
        rd(1, 0, 4'd0, 8'h00, 1'b0, "z_a_p0");
        rd(1, 1, 4'd1, 8'h31, 1'b0, "z_a_p1");
        rd(1, 2, 4'd2, 8'h32, 1'b0, "z_a_p2");
        #2; drain_rd(); step();
        rd(1, 0, 4'd3, 8'h00, 1'b1, "z_b_p0");
        rd(1, 1, 4'd2, 8'h32, 1'b0, "z_b_p1");
        rd(1, 2, 4'd1, 8'h31, 1'b0, "z_b_p2");
        #2; drain_rd(); step();
        check("z_wr_err", 32'(z_wr_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
